// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt priority controller: default sizing,
// FSM state encoding, the priority-level type and a one-hot helper.
package irq_ctrl_pkg;

  localparam int NUM_CH_DEF = 9;
  localparam int LVL_W_DEF  = 2;
  localparam int VEC_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_PRESENT = 2'd2
  } irq_state_e;

  typedef logic [LVL_W_DEF-1:0] lvl_t;

  // One-hot decode of a channel index; callers truncate to their channel count.
  function automatic logic [15:0] vec_onehot(input logic [VEC_W-1:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational winner selection: among eligible channels choose the highest
// level; on equal levels the lowest index wins.
module irq_prio_pick
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int LVL_W  = LVL_W_DEF
) (
  input  logic [NUM_CH-1:0]       eligible,
  input  logic [NUM_CH*LVL_W-1:0] levels,
  output logic                    valid,
  output logic [VEC_W-1:0]        index,
  output logic [LVL_W-1:0]        level
);

  // Scan upward; only a strictly greater level displaces the current best,
  // so a tie keeps the lower index already chosen.
  always_comb begin
    valid = 1'b0;
    index = '0;
    level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (eligible[i] && (!valid || (levels[i*LVL_W +: LVL_W] > level))) begin
        valid = 1'b1;
        index = VEC_W'(i);
        level = levels[i*LVL_W +: LVL_W];
      end
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller. Rising edges on req_i latch pending bits;
// enabled pending channels are arbitrated by level and the winner is
// presented on irq_o/vec_o/lvl_o until acknowledged.
//
// Handshake: irq_o acts as valid and ack_i as ready. While irq_o is high,
// vec_o/lvl_o are stable; the transfer completes on the rising edge where
// irq_o and ack_i are both high, after which irq_o drops for at least one
// cycle. ack_i is ignored whenever irq_o is low.
module irq_priority_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int LVL_W  = LVL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              cfg_we,
  input  logic [VEC_W-1:0]  cfg_addr,
  input  logic [NUM_CH-1:0] cfg_wdata,
  input  logic              ack_i,
  output logic              irq_o,
  output logic [VEC_W-1:0]  vec_o,
  output logic [LVL_W-1:0]  lvl_o,
  output logic [NUM_CH-1:0] pending_o,
  output irq_state_e        state_dbg
);

  irq_state_e state_q, state_d;

  logic [NUM_CH-1:0]       req_q;
  logic [NUM_CH-1:0]       pending_q;
  logic [NUM_CH-1:0]       mask_q;
  logic [LVL_W-1:0]        lvl_q [NUM_CH];
  logic [NUM_CH*LVL_W-1:0] lvl_flat;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] clr;

  logic              win_valid;
  logic [VEC_W-1:0]  win_idx;
  logic [LVL_W-1:0]  win_lvl;

  logic load_win;
  logic ack_take;
  logic cfg_mask_hit;

  assign rise         = req_i & ~req_q;
  assign eligible     = pending_q & mask_q;
  assign cfg_mask_hit = cfg_we && (cfg_addr == VEC_W'(NUM_CH));
  assign pending_o    = pending_q;
  assign state_dbg    = state_q;

  // Flatten the per-channel level registers for the picker.
  always_comb begin
    lvl_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lvl_flat[i*LVL_W +: LVL_W] = lvl_q[i];
    end
  end

  irq_prio_pick #(
    .NUM_CH (NUM_CH),
    .LVL_W  (LVL_W)
  ) u_pick (
    .eligible (eligible),
    .levels   (lvl_flat),
    .valid    (win_valid),
    .index    (win_idx),
    .level    (win_lvl)
  );

  // Request edge history; cleared to 0 so a line already high at reset
  // release is seen as a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else begin
      req_q <= req_i;
    end
  end

  // Pending register: a new edge wins over a same-cycle acknowledge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

  // Configuration registers: mask (1 = enabled) and per-channel levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        lvl_q[i] <= '0;
      end
    end else begin
      if (cfg_mask_hit) begin
        mask_q <= cfg_wdata;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && (cfg_addr == VEC_W'(i))) begin
          lvl_q[i] <= cfg_wdata[LVL_W-1:0];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (|eligible) state_d = ST_ARB;
      ST_ARB:     state_d = win_valid ? ST_PRESENT : ST_IDLE;
      ST_PRESENT: if (ack_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: winner load, acknowledge acceptance, pending clear.
  always_comb begin
    load_win = 1'b0;
    ack_take = 1'b0;
    clr      = '0;
    unique case (state_q)
      ST_ARB:     load_win = win_valid;
      ST_PRESENT: ack_take = ack_i;
      default:    ;
    endcase
    if (ack_take) begin
      clr = NUM_CH'(vec_onehot(vec_o));
    end
  end

  // Registered presentation outputs; vec_o/lvl_o only change on a winner load,
  // so config writes during presentation cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_o <= 1'b0;
      vec_o <= '0;
      lvl_o <= '0;
    end else begin
      irq_o <= (state_d == ST_PRESENT);
      if (load_win) begin
        vec_o <= win_idx;
        lvl_o <= win_lvl;
      end
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl: a cycle table for the basic and
// ordering scenarios, then hand-written sequences for masking, same-cycle
// set/ack, non-preemption, reset during presentation and reset release.
module tb_irq_priority_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NC = 9;

  logic          clk;
  logic          rst;
  logic [NC-1:0] req_i;
  logic          cfg_we;
  logic [3:0]    cfg_addr;
  logic [NC-1:0] cfg_wdata;
  logic          ack_i;
  logic          irq_o;
  logic [3:0]    vec_o;
  lvl_t          lvl_o;
  logic [NC-1:0] pending_o;
  irq_state_e    state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  irq_priority_ctrl #(.NUM_CH(NC), .LVL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .ack_i     (ack_i),
    .irq_o     (irq_o),
    .vec_o     (vec_o),
    .lvl_o     (lvl_o),
    .pending_o (pending_o),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected after that edge.
  typedef struct {
    logic [NC-1:0] req;
    logic          we;
    logic [3:0]    addr;
    logic [NC-1:0] wd;
    logic          ack;
    logic          irq;
    logic [3:0]    vec;
    logic [1:0]    lvl;
    logic [NC-1:0] pend;
  } row_t;

  row_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, let the rising edge sample, return at the next falling edge.
  task automatic step(input logic [NC-1:0] req, input logic we, input logic [3:0] addr,
                      input logic [NC-1:0] wd, input logic ack);
    req_i = req; cfg_we = we; cfg_addr = addr; cfg_wdata = wd; ack_i = ack;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step('0, 1'b0, 4'd0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; ack_i = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input logic [NC-1:0] req, input logic we, input logic [3:0] addr,
                     input logic [NC-1:0] wd, input logic ack, input logic irq,
                     input logic [3:0] vec, input logic [1:0] lvl, input logic [NC-1:0] pend);
    row_t r;
    r.req = req; r.we = we; r.addr = addr; r.wd = wd; r.ack = ack;
    r.irq = irq; r.vec = vec; r.lvl = lvl; r.pend = pend;
    tbl.push_back(r);
  endtask

  initial begin
    rst = 1'b1;
    req_i = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; ack_i = 1'b0;
    #1;
    chk("async reset irq", 32'(irq_o), 32'd0);
    chk("async reset pend", 32'(pending_o), 32'd0);
    do_reset();
    chk("reset state", 32'(state_dbg), 32'(ST_IDLE));
    chk("reset vec", 32'(vec_o), 32'd0);
    chk("reset lvl", 32'(lvl_o), 32'd0);
    chk("reset mask", 32'(dut.mask_q), 32'h1FF);

    // Single channel 4: irq after two edges, ack two cycles after irq rises.
    //   req      we addr wd ack | irq vec lvl pend
    add(9'h010, 0, 0, 0, 0,   0, 0, 0, 9'h010);
    add(9'h000, 0, 0, 0, 0,   0, 0, 0, 9'h010);
    add(9'h000, 0, 0, 0, 0,   1, 4, 0, 9'h010);
    add(9'h000, 0, 0, 0, 0,   1, 4, 0, 9'h010);
    add(9'h000, 0, 0, 0, 1,   0, 4, 0, 9'h000);
    add(9'h000, 0, 0, 0, 0,   0, 4, 0, 9'h000);
    // ack with nothing presented is ignored
    add(9'h000, 0, 0, 0, 1,   0, 4, 0, 9'h000);
    // Levels ch2=1, ch7=3, ch5=3; order must be 5, 7, 2.
    add(9'h000, 1, 2, 1, 0,   0, 4, 0, 9'h000);
    add(9'h000, 1, 7, 3, 0,   0, 4, 0, 9'h000);
    add(9'h000, 1, 5, 3, 0,   0, 4, 0, 9'h000);
    add(9'h0A4, 0, 0, 0, 0,   0, 4, 0, 9'h0A4);
    add(9'h000, 0, 0, 0, 0,   0, 4, 0, 9'h0A4);
    add(9'h000, 0, 0, 0, 1,   1, 5, 3, 9'h0A4); // ack during ARB ignored
    add(9'h000, 0, 0, 0, 1,   0, 5, 3, 9'h084);
    add(9'h000, 0, 0, 0, 0,   0, 5, 3, 9'h084);
    add(9'h000, 0, 0, 0, 0,   1, 7, 3, 9'h084);
    add(9'h000, 0, 0, 0, 1,   0, 7, 3, 9'h004);
    add(9'h000, 0, 0, 0, 0,   0, 7, 3, 9'h004);
    add(9'h000, 0, 0, 0, 0,   1, 2, 1, 9'h004);
    add(9'h000, 0, 0, 0, 1,   0, 2, 1, 9'h000);

    foreach (tbl[k]) begin
      step(tbl[k].req, tbl[k].we, tbl[k].addr, tbl[k].wd, tbl[k].ack);
      chk($sformatf("row%0d irq", k), 32'(irq_o), 32'(tbl[k].irq));
      chk($sformatf("row%0d vec", k), 32'(vec_o), 32'(tbl[k].vec));
      chk($sformatf("row%0d lvl", k), 32'(lvl_o), 32'(tbl[k].lvl));
      chk($sformatf("row%0d pend", k), 32'(pending_o), 32'(tbl[k].pend));
    end

    // Masked channel 3 stays pending without irq until enabled.
    do_reset();
    step('0, 1'b1, 4'd9, 9'h1F7, 1'b0);
    step(9'h008, 1'b0, 4'd0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk($sformatf("masked irq c%0d", i), 32'(irq_o), 32'd0);
    end
    chk("masked pend", 32'(pending_o), 32'h008);
    step('0, 1'b1, 4'd9, 9'h1FF, 1'b0);
    chk("unmask irq e0", 32'(irq_o), 32'd0);
    idle();
    chk("unmask irq e1", 32'(irq_o), 32'd0);
    idle();
    chk("unmask irq e2", 32'(irq_o), 32'd1);
    chk("unmask vec", 32'(vec_o), 32'd3);
    step('0, 1'b0, 4'd0, '0, 1'b1);
    chk("unmask ack pend", 32'(pending_o), 32'd0);

    // New edge on ch1 in the ack cycle keeps it pending and re-presents it.
    do_reset();
    step(9'h002, 1'b0, 4'd0, '0, 1'b0);
    idle();
    idle();
    chk("ch1 irq", 32'(irq_o), 32'd1);
    chk("ch1 vec", 32'(vec_o), 32'd1);
    step(9'h002, 1'b0, 4'd0, '0, 1'b1);
    chk("set-wins irq", 32'(irq_o), 32'd0);
    chk("set-wins pend", 32'(pending_o), 32'h002);
    idle();
    idle();
    chk("ch1 again irq", 32'(irq_o), 32'd1);
    chk("ch1 again vec", 32'(vec_o), 32'd1);
    step('0, 1'b0, 4'd0, '0, 1'b1);
    chk("ch1 again ack pend", 32'(pending_o), 32'd0);

    // No preemption; config writes during presentation do not disturb outputs.
    do_reset();
    step('0, 1'b1, 4'd8, 9'h003, 1'b0);
    step(9'h001, 1'b0, 4'd0, '0, 1'b0);
    idle();
    idle();
    chk("ch0 irq", 32'(irq_o), 32'd1);
    step(9'h100, 1'b0, 4'd0, '0, 1'b0);
    idle();
    idle();
    chk("nopreempt vec", 32'(vec_o), 32'd0);
    chk("nopreempt pend", 32'(pending_o), 32'h101);
    step('0, 1'b1, 4'd0, 9'h002, 1'b0);
    chk("lvl write in present", 32'(lvl_o), 32'd0);
    step('0, 1'b1, 4'd9, 9'h1FE, 1'b0);
    chk("mask write in present irq", 32'(irq_o), 32'd1);
    chk("mask write in present vec", 32'(vec_o), 32'd0);
    step('0, 1'b1, 4'd9, 9'h1FF, 1'b0);
    step('0, 1'b0, 4'd0, '0, 1'b1);
    chk("ch0 ack irq", 32'(irq_o), 32'd0);
    chk("ch0 ack pend", 32'(pending_o), 32'h100);
    idle();
    idle();
    chk("ch8 irq", 32'(irq_o), 32'd1);
    chk("ch8 vec", 32'(vec_o), 32'd8);
    chk("ch8 lvl", 32'(lvl_o), 32'd3);
    step('0, 1'b0, 4'd0, '0, 1'b1);

    // Reset during presentation with three pending; req[5] held through release.
    do_reset();
    step('0, 1'b1, 4'd2, 9'h001, 1'b0);
    step(9'h007, 1'b0, 4'd0, '0, 1'b0);
    idle();
    idle();
    chk("pre-rst irq", 32'(irq_o), 32'd1);
    chk("pre-rst vec", 32'(vec_o), 32'd2);
    chk("pre-rst pend", 32'(pending_o), 32'h007);
    rst = 1'b1;
    req_i = 9'h020;
    #1;
    chk("rst irq", 32'(irq_o), 32'd0);
    chk("rst pend", 32'(pending_o), 32'd0);
    chk("rst vec", 32'(vec_o), 32'd0);
    chk("rst lvl", 32'(lvl_o), 32'd0);
    chk("rst state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst mask", 32'(dut.mask_q), 32'h1FF);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    step(9'h020, 1'b0, 4'd0, '0, 1'b0);
    chk("release edge pend", 32'(pending_o), 32'h020);
    step(9'h020, 1'b0, 4'd0, '0, 1'b0);
    chk("release irq e1", 32'(irq_o), 32'd0);
    step(9'h020, 1'b0, 4'd0, '0, 1'b0);
    chk("release irq", 32'(irq_o), 32'd1);
    chk("release vec", 32'(vec_o), 32'd5);
    step(9'h020, 1'b0, 4'd0, '0, 1'b1);
    chk("release ack pend", 32'(pending_o), 32'd0);
    idle();
    idle();
    chk("no re-trigger on level", 32'(irq_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1);
  end

endmodule
